// File: rtl/winograd_phase_accum_if.sv
// Partial-sum input stream and result stream of the polyphase accumulator.
// The DUT uses the slave view; a producer/consumer uses the master view.
interface winograd_phase_accum_if #(
    parameter int WIDTH = 16,
    parameter int NPH   = 4
);
    localparam int PW = (NPH > 1) ? $clog2(NPH) : 1;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic [PW-1:0]           in_phase;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_sat;

    modport master (
        output in_valid, in_data, in_phase, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_phase, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/winograd_phase_accum.sv
// Sums NPH polyphase partial products per output pixel, then shifts and
// saturates the sum; walks one ROWS x COLS frame per start.
module winograd_phase_accum #(
    parameter int WIDTH = 16,
    parameter int NPH   = 4,
    parameter int ROWS  = 112,
    parameter int COLS  = 112,
    parameter int SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    winograd_phase_accum_if.slave  s,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int PW   = (NPH > 1) ? $clog2(NPH) : 1;
    localparam int AW   = WIDTH + $clog2(NPH) + 1;
    localparam int NPIX = ROWS * COLS;
    localparam int PXW  = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic signed [AW-1:0] MAX_V = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, OUT, DONE} state_t;

    state_t                  state_reg;
    logic signed [AW-1:0]    acc_reg;
    logic [PW-1:0]           phase_reg;
    logic [PXW-1:0]          pix_reg;
    logic                    in_ready_reg;
    logic                    out_valid_reg;
    logic signed [WIDTH-1:0] out_data_reg;
    logic                    out_sat_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    err_reg;

    logic                    take;
    logic signed [AW-1:0]    sum_next;
    logic signed [AW-1:0]    shifted;
    logic                    sat_hi;
    logic                    sat_lo;
    logic signed [WIDTH-1:0] sat_data;

    // in_ready_reg is high exactly in ACCUM, so it doubles as the state qualifier
    always_comb begin
        take     = s.in_valid && in_ready_reg;
        sum_next = acc_reg + {{(AW-WIDTH){s.in_data[WIDTH-1]}}, s.in_data};
        shifted  = sum_next >>> SHIFT;
        sat_hi   = shifted > MAX_V;
        sat_lo   = shifted < MIN_V;
        sat_data = shifted[WIDTH-1:0];
        if (sat_hi) begin
            sat_data = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (sat_lo) begin
            sat_data = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            phase_reg     <= '0;
            pix_reg       <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= ACCUM;
                        acc_reg      <= '0;
                        phase_reg    <= '0;
                        pix_reg      <= '0;
                        err_reg      <= 1'b0;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (take) begin
                        // An out-of-order phase is flagged but still summed
                        if (s.in_phase != phase_reg) begin
                            err_reg <= 1'b1;
                        end
                        if (phase_reg == PW'(NPH - 1)) begin
                            state_reg     <= OUT;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                            out_data_reg  <= sat_data;
                            out_sat_reg   <= sat_hi | sat_lo;
                            acc_reg       <= '0;
                            phase_reg     <= '0;
                        end else begin
                            acc_reg   <= sum_next;
                            phase_reg <= phase_reg + PW'(1);
                        end
                    end
                end
                OUT: begin
                    if (s.out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (pix_reg == PXW'(NPIX - 1)) begin
                            pix_reg   <= '0;
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            pix_reg      <= pix_reg + PXW'(1);
                            state_reg    <= ACCUM;
                            in_ready_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign s.in_ready  = in_ready_reg;
    assign s.out_valid = out_valid_reg;
    assign s.out_data  = out_data_reg;
    assign s.out_sat   = out_sat_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign err         = err_reg;
endmodule

// File: tb/tb_winograd_phase_accum.sv
// Drives two accumulators (SHIFT=0 and SHIFT=2) with identical streams and
// compares both against a plain-arithmetic sum/shift/clip reference.
module tb_winograd_phase_accum;
    localparam int WIDTH = 16;
    localparam int NPH   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy_a, done_a, err_a, busy_b, done_b, err_b;

    winograd_phase_accum_if #(.WIDTH(WIDTH), .NPH(NPH)) ifa ();
    winograd_phase_accum_if #(.WIDTH(WIDTH), .NPH(NPH)) ifb ();

    winograd_phase_accum #(.WIDTH(WIDTH), .NPH(NPH), .ROWS(2), .COLS(2), .SHIFT(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .s(ifa.slave),
        .busy(busy_a), .done(done_a), .err(err_a)
    );
    winograd_phase_accum #(.WIDTH(WIDTH), .NPH(NPH), .ROWS(2), .COLS(2), .SHIFT(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .s(ifb.slave),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_d[4];
    int cur_ph[4];
    bit err_exp;
    bit poke_start;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clip(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic drive_in(input bit v, input int d, input int ph);
        ifa.in_valid = v; ifb.in_valid = v;
        ifa.in_data  = 16'(d); ifb.in_data = 16'(d);
        ifa.in_phase = 2'(ph); ifb.in_phase = 2'(ph);
    endtask

    task automatic set_ready(input bit r);
        ifa.out_ready = r; ifb.out_ready = r;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_frame;
        start = 1'b1;
        tick();
        start = 1'b0;
        err_exp = 1'b0;
        chk("busy_after_start", int'(busy_a), 1);
        chk("err_cleared", int'(err_a), 0);
        chk("in_ready_accum", int'(ifa.in_ready), 1);
    endtask

    // One pixel: NPH samples, optional output stall, then the handshake.
    task automatic run_pixel(input int stall, input bit last);
        int sum;
        int exp_a, exp_b;
        sum = 0;
        for (int i = 0; i < NPH; i++) begin
            chk("in_ready_phase", int'(ifa.in_ready), 1);
            drive_in(1'b1, cur_d[i], cur_ph[i]);
            start = poke_start && (i == 1);
            if (cur_ph[i] != i) err_exp = 1'b1;
            sum += cur_d[i];
            tick();
        end
        start = 1'b0;
        drive_in(1'b0, 0, 0);
        exp_a = clip(sum);
        exp_b = clip(sum >>> 2);
        $display("pixel sum=%0d out_a=%0d out_b=%0d sat_a=%0b sat_b=%0b stall=%0d",
                 sum, $signed(ifa.out_data), $signed(ifb.out_data), ifa.out_sat, ifb.out_sat, stall);
        chk("out_valid_a", int'(ifa.out_valid), 1);
        chk("out_valid_b", int'(ifb.out_valid), 1);
        chk("out_data_a", int'(ifa.out_data), exp_a);
        chk("out_data_b", int'(ifb.out_data), exp_b);
        chk("out_sat_a", int'(ifa.out_sat), int'(exp_a != sum));
        chk("out_sat_b", int'(ifb.out_sat), int'(exp_b != (sum >>> 2)));
        for (int k = 0; k < stall; k++) begin
            set_ready(1'b0);
            tick();
            chk("stall_valid", int'(ifa.out_valid), 1);
            chk("stall_data", int'(ifa.out_data), exp_a);
            chk("stall_in_ready", int'(ifa.in_ready), 0);
        end
        set_ready(1'b1);
        tick();
        set_ready(1'b0);
        chk("out_valid_drop", int'(ifa.out_valid), 0);
        chk("err_a", int'(err_a), int'(err_exp));
        chk("err_b", int'(err_b), int'(err_exp));
        if (last) begin
            chk("done_pulse", int'(done_a), 1);
            tick();
            chk("done_single", int'(done_a), 0);
            chk("busy_idle_a", int'(busy_a), 0);
            chk("busy_idle_b", int'(busy_b), 0);
        end else begin
            chk("done_low", int'(done_a), 0);
            chk("in_ready_next", int'(ifa.in_ready), 1);
        end
    endtask

    task automatic load(input int d0, d1, d2, d3, input int p0, p1, p2, p3);
        cur_d[0] = d0; cur_d[1] = d1; cur_d[2] = d2; cur_d[3] = d3;
        cur_ph[0] = p0; cur_ph[1] = p1; cur_ph[2] = p2; cur_ph[3] = p3;
    endtask

    task automatic load_random(input bit big);
        logic signed [15:0] r;
        for (int i = 0; i < NPH; i++) begin
            r = 16'($urandom);
            if (big) r = (r < 0) ? 16'(-32768 + int'($urandom_range(0, 4000)))
                                 : 16'(32767 - int'($urandom_range(0, 4000)));
            cur_d[i]  = int'(r);
            cur_ph[i] = i;
        end
    endtask

    initial begin
        poke_start = 1'b0;
        drive_in(1'b0, 0, 0);
        set_ready(1'b0);
        @(negedge clk);
        tick();
        tick();
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_in_ready", int'(ifa.in_ready), 0);
        chk("rst_out_valid", int'(ifa.out_valid), 0);
        chk("rst_out_data", int'(ifa.out_data), 0);
        chk("rst_done", int'(done_a), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", int'(ifa.in_ready), 0);

        // Frame 1: directed values, stall on pixel 2
        start_frame();
        load(10, -3, 7, 1, 0, 1, 2, 3);                 run_pixel(0, 1'b0);
        load(32767, 32767, 32767, 32767, 0, 1, 2, 3);   run_pixel(3, 1'b0);
        load(-32768, -32768, -32768, -32768, 0, 1, 2, 3); run_pixel(0, 1'b0);
        load(5, 5, 5, -2, 0, 1, 2, 3);                  run_pixel(1, 1'b1);
        tick();
        chk("start_needed", int'(ifa.in_ready), 0);

        // Frame 2: phase-order error sticks through the frame
        start_frame();
        load(-1, 0, 0, 0, 0, 2, 2, 3);                  run_pixel(0, 1'b0);
        for (int p = 1; p < 4; p++) begin
            load_random(1'b0);
            run_pixel(int'($urandom_range(0, 2)), p == 3);
        end

        // Frame 3: err cleared by start; start pulsed mid-pixel is ignored
        start_frame();
        for (int p = 0; p < 4; p++) begin
            load_random(p[0]);
            poke_start = (p == 1);
            run_pixel(int'($urandom_range(0, 2)), p == 3);
        end
        poke_start = 1'b0;

        // Reset mid-pixel, with err already set
        start_frame();
        drive_in(1'b1, 100, 0); tick();
        drive_in(1'b1, 200, 3); tick();
        drive_in(1'b0, 0, 0);
        chk("err_before_rst", int'(err_a), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_busy", int'(busy_a), 0);
        chk("mid_rst_err", int'(err_a), 0);
        chk("mid_rst_in_ready", int'(ifa.in_ready), 0);
        chk("mid_rst_out_valid", int'(ifa.out_valid), 0);
        chk("mid_rst_out_data", int'(ifa.out_data), 0);
        chk("mid_rst_out_sat", int'(ifa.out_sat), 0);
        chk("mid_rst_done", int'(done_a), 0);
        tick();
        chk("no_stray_out", int'(ifa.out_valid), 0);

        start_frame();
        load(1, 1, 1, 1, 1, 1, 1, 1);                   run_pixel(0, 1'b0);
        for (int p = 1; p < 4; p++) begin
            load_random(1'b0);
            run_pixel(int'($urandom_range(0, 1)), p == 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/winograd_phase_accum.md
WINOGRAD_PHASE_ACCUM -- requirements
Module: winograd_phase_accum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning signed sample width of inputs and output.
REQ-002 The block SHALL have parameter NPH, default 4, meaning number of polyphase partial sums per output pixel (legal 1..8).
REQ-003 The block SHALL have parameter ROWS, default 112, meaning output rows per frame.
REQ-004 The block SHALL have parameter COLS, default 112, meaning output columns per frame.
REQ-005 The block SHALL have parameter SHIFT, default 0, meaning arithmetic right shift applied to the phase sum before saturation.
REQ-006 The block SHALL have port clk, input, 1, clock; all logic on rising edge only.
REQ-007 The block SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-008 The block SHALL have port start, input, 1, begins a frame when sampled in IDLE.
REQ-009 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, WIDTH, signed), in_phase (input, max(1,clog2(NPH))), forming the partial-sum input stream.
REQ-010 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, WIDTH, signed), out_sat (output, 1, out_data was clipped), forming the result stream.
REQ-011 The block SHALL have outputs busy (1, not IDLE), done (1, one-cycle frame-complete pulse), err (1, sticky phase-order error).

Function
REQ-012 States SHALL be IDLE, ACCUM, OUT, DONE.
REQ-013 IDLE: in_ready=0, out_valid=0; start=1 -> ACCUM with acc=0, phase count=0, pixel count=0, err cleared.
REQ-014 start SHALL be ignored outside IDLE.
REQ-015 ACCUM: in_ready=1; a transfer occurs when in_valid&&in_ready; each transfer adds sign-extended in_data to acc and increments phase count.
REQ-016 Accumulator width SHALL be WIDTH+clog2(NPH)+1 bits; no internal overflow is possible.
REQ-017 If in_phase differs from the expected phase count on a transfer, err SHALL set and hold until next start; the sample SHALL still be accumulated.
REQ-018 On the NPH-th transfer the block SHALL go to OUT next cycle with out_data = saturate(full_sum >>> SHIFT), full_sum including that final sample; latency from final accept to out_valid = 1 cycle.
REQ-019 Saturation SHALL clip to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; out_sat=1 exactly when clipping occurred.
REQ-020 OUT: out_valid=1, in_ready=0, out_data/out_sat stable until out_ready=1.
REQ-021 On out_valid&&out_ready: pixel count increments; if it was the ROWS*COLS-th pixel -> DONE, else -> ACCUM with acc=0, phase count=0.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE; busy=0 only in IDLE.
REQ-023 Pixel counter SHALL wrap to 0 after the last pixel; no partial frame is emitted.
REQ-024 NPH=1 SHALL work: every accepted sample produces one output.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, acc=0, counters=0, out_data=0, out_valid=0, out_sat=0, in_ready=0, busy=0, done=0, err=0, including mid-frame; no output is emitted for the interrupted pixel.

Verification
REQ-026 NPH=4, SHIFT=0, phases 0..3 data 10,-3,7,1 -> one cycle after last accept out_valid=1, out_data=15, out_sat=0.
REQ-027 WIDTH=16, four samples 32767 -> out_data=32767, out_sat=1; four samples -32768 -> out_data=-32768, out_sat=1.
REQ-028 SHIFT=2, data 5,5,5,-2 -> out_data=3 (13>>>2); data -1,0,0,0 -> out_data=-1.
REQ-029 ROWS=COLS=2, 16 samples, out_ready held low 3 cycles on pixel 2 -> out_data stable, in_ready=0 throughout stall, done pulses once after 4th output, then busy=0.
REQ-030 in_phase sequence 0,2,2,3 -> err=1 stays high through frame, output still sum of all four; next start clears err.
REQ-031 rst_n=0 after 2 of 4 phases -> next cycle IDLE, all outputs 0; new start, phases 1,1,1,1 -> out_data=4.
